// File: rtl/pending_mask_32_if.sv
// pending_mask_32_if: request, handshake and status signals of the pending tracker
//   master (producer/consumer side) drives SetMask/SetValid, ClrMask/ClrValid, OutReady
//   slave  (tracker side) drives OutIndex/OutValid, Pending, Count, DupErr
interface pending_mask_32_if;
    logic [31:0] SetMask;
    logic        SetValid;
    logic [31:0] ClrMask;
    logic        ClrValid;
    logic [4:0]  OutIndex;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Pending;
    logic [5:0]  Count;
    logic        DupErr;
    modport master (
        output SetMask, SetValid, ClrMask, ClrValid, OutReady,
        input  OutIndex, OutValid, Pending, Count, DupErr
    );
    modport slave (
        input  SetMask, SetValid, ClrMask, ClrValid, OutReady,
        output OutIndex, OutValid, Pending, Count, DupErr
    );
endinterface

// File: rtl/pending_mask_32.sv
// pending_mask_32: accumulates set requests into a 32-bit pending set and hands indices out one at a time
//   Clk    : rising-edge clock
//   nReset : synchronous active-low reset
//   bus    : slave side of pending_mask_32_if (set/clear masks in, index handshake and status out)
module pending_mask_32 #(
    parameter bit LOWEST_FIRST = 1'b1
) (
    input  logic              Clk,
    input  logic              nReset,
    pending_mask_32_if.slave  bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pend;
    logic [5:0]  r_cnt;
    logic [4:0]  r_idx;
    logic        r_dup;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_avail;
    logic [31:0] w_loadbit;
    logic [31:0] w_pend_next;
    logic [5:0]  w_cnt_next;
    logic [4:0]  w_cand;
    logic        w_load;
    logic        w_dup_hit;

    assign w_set       = bus.SetValid ? bus.SetMask : '0;
    assign w_clr       = bus.ClrValid ? bus.ClrMask : '0;
    assign w_avail     = r_pend & ~w_clr;
    assign w_loadbit   = 32'(w_load) << w_cand;
    // set is OR-ed last so it wins over both clear and load on the same bit
    assign w_pend_next = (r_pend & ~w_clr & ~w_loadbit) | w_set;
    assign w_dup_hit   = (|(w_set & r_pend)) || (r_state == PRESENT && w_set[r_idx]);

    // scan away from the preferred end so the preferred end is written last and wins
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < 32; i++) begin
            if (w_avail[LOWEST_FIRST ? 31 - i : i]) w_cand = 5'(LOWEST_FIRST ? 31 - i : i);
        end
    end

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < 32; i++) w_cnt_next = w_cnt_next + 6'(w_pend_next[i]);
    end

    always_comb begin
        w_load       = (|w_avail) && (r_state == IDLE || bus.OutReady);
        w_state_next = w_load ? PRESENT : (r_state == PRESENT && !bus.OutReady) ? PRESENT : IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dup   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_load ? w_cand : r_idx;
            r_dup   <= r_dup | w_dup_hit;
        end
    end

    assign bus.OutIndex = r_idx;
    assign bus.OutValid = (r_state == PRESENT);
    assign bus.Pending  = r_pend;
    assign bus.Count    = r_cnt;
    assign bus.DupErr   = r_dup;
endmodule
